mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one physical memory port between the pipeline's instruction-fetch port and data port. Accepts a read request from fetch and a read/write request from the MEM stage, grants one at a time with round-robin priority on contention, and holds the granted address, data and byte enables stable on the memory side until the memory responds. Returns the response and read data to the granted requester. A watchdog aborts transactions that the memory never completes.

## Interface
- XLEN, 32: address/data width.
- TIMEOUT, 64: maximum busy cycles before abort; 0 disables the watchdog.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr_read  in  1  fetch request; held until instr_resp.
- instr_address  in  XLEN  fetch address.
- instr_resp  out  1  one-cycle completion pulse to fetch.
- instr_rdata  out  XLEN  fetch read data, valid with instr_resp.
- data_read  in  1  data read request; held until data_resp.
- data_write  in  1  data write request; held until data_resp. Never asserted together with data_read.
- data_address  in  XLEN  data address.
- data_wdata  in  XLEN  write data.
- data_mbe  in  4  write byte enables.
- data_resp  out  1  one-cycle completion pulse to the data side.
- data_rdata  out  XLEN  data read data, valid with data_resp.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_mbe  out  4  memory byte enables.
- mem_resp  in  1  memory completion, one cycle.
- mem_rdata  in  XLEN  memory read data, valid with mem_resp.
- mem_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States:
  - IDLE: no transaction in flight.
  - I_BUSY: fetch transaction in flight.
  - D_BUSY: data transaction in flight.
- Grant, evaluated in IDLE on each rising edge:
  - Only instr_read asserted -> I_BUSY.
  - Only data_read or data_write asserted -> D_BUSY.
  - Both sides requesting -> grant the side not granted last; last_grant resets to "instr", so the first contention goes to data.
- On grant, register the mem_* outputs from the granted side's inputs. For fetch: mem_read=1, mem_mbe=4'hF, mem_wdata=0. They stay constant for the whole busy state.
- mem_resp seen in a BUSY state completes the transaction:
  - <side>_resp = mem_resp, gated by state (combinational).
  - <side>_rdata = mem_rdata while that state is active; 0 otherwise.
  - Next state is IDLE, mem_read/mem_write clear, and last_grant updates.
- mem_resp seen in IDLE is ignored. No resp pulse is produced.
- Watchdog (active when TIMEOUT≠0):
  - Counter clears on grant and increments each BUSY cycle without mem_resp.
  - On the cycle the counter equals TIMEOUT-1 with no mem_resp: mem_err=1 and <side>_resp=1 with <side>_rdata=0, then IDLE.
  - A mem_resp arriving on that same cycle wins; there is no error.
- A requester dropping its request mid-transaction is a protocol violation. The arbiter still completes the transaction and pulses resp.
- Reset:
  - While rst=0, all outputs are 0, state is IDLE, the counter is 0 and last_grant is instr.
  - Reset asserted mid-transaction aborts it with no resp and no mem_err.

## Timing
- All mem_* outputs are registered. *_resp, *_rdata and mem_err are combinational from state and mem_resp/mem_rdata.
- Minimum transaction: request sampled at edge N; mem strobe high in cycle N+1; mem_resp at N+1 gives resp in cycle N+1. The requester then drops its request, so it is seen low at the next grant evaluation (edge N+2).
- Back-to-back: one IDLE cycle between transactions, so 2 cycles per transaction minimum.
- With both ports continuously requesting, grants strictly alternate D, I, D, I….
- Memory latency L cycles (mem_resp L-1 cycles after the strobe rises) gives a total of L+1 cycles from the request edge.

## Test plan
- Isolated fetch: instr_read, address 0x40, memory responds 3 cycles later with 0xDEADBEEF -> mem_read=1 and mem_address=0x40 for 3 cycles, then one instr_resp pulse with instr_rdata=0xDEADBEEF; data_resp stays 0.
- Isolated write: data_write, address 0x104, wdata 0x000000AA, mbe 4'b0001 -> mem_write with exactly those values held until mem_resp, then one data_resp; mem_read stays 0.
- Contention: both sides request continuously after reset, each memory op takes 1 cycle -> grant order D, I, D, I. No grant is repeated while the other side is pending.
- Watchdog: TIMEOUT=8, fetch with no mem_resp -> mem_err and instr_resp high on the 8th busy cycle, instr_rdata=0, state back to IDLE. A repeat run with mem_resp on exactly that cycle -> no mem_err and rdata equals mem_rdata.
- Reset mid-transaction: drop rst while in D_BUSY -> all outputs 0 immediately (asynchronous), no data_resp. After release, a pending fetch is granted normally.
- Stray response: pulse mem_resp while IDLE -> no resp pulses, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of its surroundings.
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            instr_read;
  logic [XLEN-1:0] instr_address;
  logic            instr_resp;
  logic [XLEN-1:0] instr_rdata;

  logic            data_read;
  logic            data_write;
  logic [XLEN-1:0] data_address;
  logic [XLEN-1:0] data_wdata;
  logic [3:0]      data_mbe;
  logic            data_resp;
  logic [XLEN-1:0] data_rdata;

  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_mbe;
  logic            mem_resp;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  modport slave (
    input  instr_read, instr_address,
    input  data_read, data_write, data_address, data_wdata, data_mbe,
    input  mem_resp, mem_rdata,
    output instr_resp, instr_rdata,
    output data_resp, data_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_mbe, mem_err
  );

  modport master (
    output instr_read, instr_address,
    output data_read, data_write, data_address, data_wdata, data_mbe,
    output mem_resp, mem_rdata,
    input  instr_resp, instr_rdata,
    input  data_resp, data_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_mbe, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters,
// with a watchdog that aborts transactions the memory never completes.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [XLEN-1:0]  mem_address_q, mem_address_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_mbe_q, mem_mbe_d;

  logic wd_en_c;
  logic busy_c;
  logic i_busy_c;
  logic d_busy_c;
  logic timeout_hit_c;
  logic instr_req_c;
  logic data_req_c;
  logic grant_data_c;

  // Watchdog fires on the last allowed busy cycle; a same-cycle response takes precedence.
  always_comb begin
    wd_en_c       = (TIMEOUT != 0);
    i_busy_c      = (state_q == ST_I_BUSY);
    d_busy_c      = (state_q == ST_D_BUSY);
    busy_c        = i_busy_c | d_busy_c;
    timeout_hit_c = wd_en_c && busy_c && !bus.mem_resp &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));
    instr_req_c   = bus.instr_read;
    data_req_c    = bus.data_read | bus.data_write;
    grant_data_c  = data_req_c && (!instr_req_c || (last_grant_q == GRANT_I));
  end

  // Next-state and memory-side register updates.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mbe_d     = mem_mbe_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data_c) begin
          state_d       = ST_D_BUSY;
          cnt_d         = '0;
          mem_read_d    = bus.data_read;
          mem_write_d   = bus.data_write;
          mem_address_d = bus.data_address;
          mem_wdata_d   = bus.data_wdata;
          mem_mbe_d     = bus.data_mbe;
        end else if (instr_req_c) begin
          state_d       = ST_I_BUSY;
          cnt_d         = '0;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = bus.instr_address;
          mem_wdata_d   = '0;
          mem_mbe_d     = 4'hF;
        end
      end

      ST_I_BUSY, ST_D_BUSY: begin
        if (bus.mem_resp || timeout_hit_c) begin
          state_d      = ST_IDLE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = d_busy_c ? GRANT_D : GRANT_I;
        end else if (wd_en_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_I;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_mbe_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mbe_q     <= mem_mbe_d;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_mbe     = mem_mbe_q;

  // Responses are steered by state; an aborted transaction returns zero data.
  assign bus.instr_resp  = i_busy_c && (bus.mem_resp || timeout_hit_c);
  assign bus.instr_rdata = (i_busy_c && !timeout_hit_c) ? bus.mem_rdata : '0;
  assign bus.data_resp   = d_busy_c && (bus.mem_resp || timeout_hit_c);
  assign bus.data_rdata  = (d_busy_c && !timeout_hit_c) ? bus.mem_rdata : '0;
  assign bus.mem_err     = timeout_hit_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter: grants, round-robin, watchdog, reset and stray responses.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  bit   exp_d;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst               = 1'b0;
    bus.instr_read    = 1'b1;
    bus.instr_address = 32'h0000_0010;
    bus.data_read     = 1'b0;
    bus.data_write    = 1'b0;
    bus.data_address  = '0;
    bus.data_wdata    = '0;
    bus.data_mbe      = '0;
    bus.mem_resp      = 1'b1;
    bus.mem_rdata     = 32'hCAFE_F00D;

    // reset holds every output low even with requests and a response present
    tick();
    tick();
    check("rst_mem_read",  32'(bus.mem_read),  32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr",  bus.mem_address,    32'd0);
    check("rst_mem_mbe",   32'(bus.mem_mbe),   32'd0);
    check("rst_iresp",     32'(bus.instr_resp), 32'd0);
    check("rst_irdata",    bus.instr_rdata,    32'd0);
    check("rst_dresp",     32'(bus.data_resp), 32'd0);
    check("rst_err",       32'(bus.mem_err),   32'd0);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    rst = 1'b1;

    // contention from reset: D, I, D, I with single-cycle memory
    bus.instr_read    = 1'b1;
    bus.instr_address = 32'h0000_0200;
    bus.data_read     = 1'b1;
    bus.data_address  = 32'h0000_0300;
    for (int g = 0; g < 4; g++) begin
      exp_d = ((g % 2) == 0);
      tick();
      check("cont_addr",  bus.mem_address, exp_d ? 32'h300 : 32'h200);
      check("cont_read",  32'(bus.mem_read), 32'd1);
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h100 + 32'(g);
      #1;
      check("cont_dresp", 32'(bus.data_resp),  32'(exp_d));
      check("cont_iresp", 32'(bus.instr_resp), 32'(!exp_d));
      check("cont_rdata", exp_d ? bus.data_rdata : bus.instr_rdata, 32'h100 + 32'(g));
      tick();
      bus.mem_resp = 1'b0;
      #1;
      check("cont_idle",  32'(bus.mem_read), 32'd0);
    end
    bus.instr_read = 1'b0;
    bus.data_read  = 1'b0;
    tick();

    // isolated fetch, memory answers on the third strobe cycle
    bus.instr_read    = 1'b1;
    bus.instr_address = 32'h0000_0040;
    tick();
    check("f_read",  32'(bus.mem_read),  32'd1);
    check("f_write", 32'(bus.mem_write), 32'd0);
    check("f_addr",  bus.mem_address,    32'h40);
    check("f_mbe",   32'(bus.mem_mbe),   32'hF);
    check("f_wdata", bus.mem_wdata,      32'd0);
    check("f_iresp0", 32'(bus.instr_resp), 32'd0);
    tick();
    check("f_read2", 32'(bus.mem_read),  32'd1);
    check("f_addr2", bus.mem_address,    32'h40);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("f_read3", 32'(bus.mem_read),   32'd1);
    check("f_iresp", 32'(bus.instr_resp), 32'd1);
    check("f_rdata", bus.instr_rdata,     32'hDEAD_BEEF);
    check("f_dresp", 32'(bus.data_resp),  32'd0);
    tick();
    bus.mem_resp   = 1'b0;
    bus.instr_read = 1'b0;
    #1;
    check("f_done_read",  32'(bus.mem_read),   32'd0);
    check("f_done_iresp", 32'(bus.instr_resp), 32'd0);

    // isolated byte write
    bus.data_write   = 1'b1;
    bus.data_address = 32'h0000_0104;
    bus.data_wdata   = 32'h0000_00AA;
    bus.data_mbe     = 4'b0001;
    tick();
    check("w_write", 32'(bus.mem_write), 32'd1);
    check("w_read",  32'(bus.mem_read),  32'd0);
    check("w_addr",  bus.mem_address,    32'h104);
    check("w_wdata", bus.mem_wdata,      32'hAA);
    check("w_mbe",   32'(bus.mem_mbe),   32'h1);
    tick();
    check("w_write2", 32'(bus.mem_write), 32'd1);
    check("w_dresp0", 32'(bus.data_resp), 32'd0);
    bus.mem_resp = 1'b1;
    #1;
    check("w_dresp", 32'(bus.data_resp),  32'd1);
    check("w_iresp", 32'(bus.instr_resp), 32'd0);
    tick();
    bus.mem_resp   = 1'b0;
    bus.data_write = 1'b0;
    #1;
    check("w_done", 32'(bus.mem_write), 32'd0);

    // watchdog abort on the 8th busy cycle
    bus.instr_read    = 1'b1;
    bus.instr_address = 32'h0000_0080;
    bus.mem_rdata     = 32'h5555_5555;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        check("wd_err_early",   32'(bus.mem_err),    32'd0);
        check("wd_iresp_early", 32'(bus.instr_resp), 32'd0);
      end else begin
        check("wd_err",    32'(bus.mem_err),    32'd1);
        check("wd_iresp",  32'(bus.instr_resp), 32'd1);
        check("wd_irdata", bus.instr_rdata,     32'd0);
      end
    end
    tick();
    bus.instr_read = 1'b0;
    check("wd_idle",    32'(bus.mem_read), 32'd0);
    check("wd_err_off", 32'(bus.mem_err),  32'd0);

    // response on the timeout cycle wins
    bus.instr_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        check("wd2_err",   32'(bus.mem_err),    32'd0);
        check("wd2_iresp", 32'(bus.instr_resp), 32'd1);
        check("wd2_rdata", bus.instr_rdata,     32'h1234_5678);
      end
    end
    tick();
    bus.mem_resp   = 1'b0;
    bus.instr_read = 1'b0;

    // stray response while idle
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("stray_iresp", 32'(bus.instr_resp), 32'd0);
    check("stray_dresp", 32'(bus.data_resp),  32'd0);
    check("stray_err",   32'(bus.mem_err),    32'd0);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    check("stray_read",  32'(bus.mem_read),  32'd0);
    check("stray_write", 32'(bus.mem_write), 32'd0);

    // reset in D_BUSY, then a pending fetch is granted normally
    bus.data_read    = 1'b1;
    bus.data_address = 32'h0000_0400;
    tick();
    check("rm_read", 32'(bus.mem_read), 32'd1);
    check("rm_addr", bus.mem_address,   32'h400);
    bus.instr_read    = 1'b1;
    bus.instr_address = 32'h0000_0500;
    bus.mem_resp      = 1'b1;
    rst               = 1'b0;
    #1;
    check("rm_async_read", 32'(bus.mem_read),   32'd0);
    check("rm_async_addr", bus.mem_address,     32'd0);
    check("rm_dresp",      32'(bus.data_resp),  32'd0);
    check("rm_iresp",      32'(bus.instr_resp), 32'd0);
    check("rm_err",        32'(bus.mem_err),    32'd0);
    bus.mem_resp  = 1'b0;
    bus.data_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rm_fetch_read", 32'(bus.mem_read), 32'd1);
    check("rm_fetch_addr", bus.mem_address,   32'h500);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hA5A5_0001;
    #1;
    check("rm_fetch_iresp", 32'(bus.instr_resp), 32'd1);
    check("rm_fetch_rdata", bus.instr_rdata,     32'hA5A5_0001);
    tick();
    bus.mem_resp   = 1'b0;
    bus.instr_read = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
